// File: rtl/truth_table_pkg.sv
// Shared types and helpers for the truth-table sweeper.
// Contents:
//   state_e        - sweeper FSM states
//   ROWS, ROW_W    - number of input rows of a 3-input gate and the row index width
//   row_bit_index  - position of a row's result bit in the hex code (row 0 lands in bit 7)
//   majority3      - 2-of-3 vote used when multi-sample capture is enabled
package truth_table_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StSample,
    StDone
  } state_e;

  localparam int unsigned ROWS  = 8;
  localparam int unsigned ROW_W = 3;

  function automatic logic [ROW_W-1:0] row_bit_index(input logic [ROW_W-1:0] row);
    return ROW_W'(ROWS - 1) - row;
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit.
// Ports:
//   clk    - destination clock
//   rst_n  - asynchronous active-low reset, clears every stage to 0
//   d      - asynchronous input
//   q      - synchronized output, STAGES clock edges behind d
module bit_synchronizer #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweep/capture stage around a 3-input logic module. Drives {in1,in2,in3} through rows
// 000..111, waits SETTLE_CYCLES per row, samples the synchronized module output and assembles
// the 8-bit truth-table code (row r -> bit 7-r), then compares it with a latched expected code.
//
// Optional feature (macro TRUTH_TABLE_SWEEPER_VOTE_EN): the sample phase lasts 3 cycles and
// the captured bit is the majority of 3 consecutive synchronized samples.
//
// Reset release on rst_n is assumed to be synchronous to clk (assertion may be asynchronous).
//
// Ports:
//   clk       - clock
//   rst_n     - asynchronous active-low reset
//   start     - one-cycle sweep request (ignored while busy or during the done pulse)
//   expected  - expected code, latched when a start is accepted
//   in1..in3  - row drive to the logic module (in1 = MSB)
//   dut_out   - logic module output, asynchronous to clk
//   busy      - sweep in progress
//   done      - one-cycle completion pulse
//   table_out - captured truth-table code, held until the next accepted start
//   match     - table_out equals the latched expected code, valid from done onward
module truth_table_sweeper
  import truth_table_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] expected,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  input  logic       dut_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] table_out,
  output logic       match
);

  localparam int unsigned CntW = $clog2(SETTLE_CYCLES + 1);

  state_e           state;
  logic [ROW_W-1:0] row;
  logic [CntW-1:0]  cnt;
  logic [7:0]       exp_code;
  logic             sync_out;
  logic             capture_now;
  logic             capture_bit;

  bit_synchronizer #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (dut_out),
    .q    (sync_out)
  );

`ifdef TRUTH_TABLE_SWEEPER_VOTE_EN
  logic [1:0] vote_idx;
  logic [1:0] votes;

  // Third sample of the window decides, together with the two stored ones.
  assign capture_now = (vote_idx == 2'd2);
  assign capture_bit = majority3(votes[1], votes[0], sync_out);
`else
  assign capture_now = 1'b1;
  assign capture_bit = sync_out;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      row       <= '0;
      cnt       <= '0;
      exp_code  <= '0;
      in1       <= 1'b0;
      in2       <= 1'b0;
      in3       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      table_out <= '0;
      match     <= 1'b0;
`ifdef TRUTH_TABLE_SWEEPER_VOTE_EN
      vote_idx  <= '0;
      votes     <= '0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          // !done rejects a start that coincides with the completion pulse.
          if (start && !done) begin
            exp_code        <= expected;
            row             <= '0;
            {in1, in2, in3} <= '0;
            cnt             <= '0;
            table_out       <= '0;
            match           <= 1'b0;
            busy            <= 1'b1;
            state           <= StSettle;
          end
        end
        StSettle: begin
          if (cnt == CntW'(SETTLE_CYCLES - 1)) begin
            cnt   <= '0;
            state <= StSample;
          end else begin
            cnt <= cnt + CntW'(1);
          end
        end
        StSample: begin
`ifdef TRUTH_TABLE_SWEEPER_VOTE_EN
          if (!capture_now) begin
            votes    <= {votes[0], sync_out};
            vote_idx <= vote_idx + 2'd1;
          end else begin
            vote_idx <= '0;
          end
`endif
          if (capture_now) begin
            table_out[row_bit_index(row)] <= capture_bit;
            if (row == ROW_W'(ROWS - 1)) begin
              // Rows stay at 111 until the next start.
              state <= StDone;
            end else begin
              row             <= row + ROW_W'(1);
              {in1, in2, in3} <= row + ROW_W'(1);
              state           <= StSettle;
            end
          end
        end
        StDone: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          match <= (table_out == exp_code);
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

  localparam int unsigned S = 4;
`ifdef TRUTH_TABLE_SWEEPER_VOTE_EN
  localparam int unsigned PER_ROW = S + 3;
`else
  localparam int unsigned PER_ROW = S + 1;
`endif
  localparam int unsigned LAT = 8 * PER_ROW + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] expected = 8'h00;
  logic       in1, in2, in3;
  logic       dut_out;
  logic       busy, done;
  logic [7:0] table_out;
  logic       match;

  // Gate model: kind 0 = XOR3, 1 = constant 1, 2 = constant 0, 3 = arbitrary code in gate_tt.
  logic [1:0] gate_kind = 2'd0;
  logic [7:0] gate_tt = 8'h00;
  logic       glitch = 1'b0;

  int unsigned edge_cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  typedef struct {
    logic [7:0]  code;
    logic        m;
    int unsigned acc;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  int         hist[8];
  logic [2:0] last_row = 3'd0;
  int         order_err = 0;

  function automatic logic gate(input logic [1:0] k, input logic [2:0] r, input logic [7:0] tt);
    int idx;
    idx = 7 - int'(r);
    case (k)
      2'd0:    return r[2] ^ r[1] ^ r[0];
      2'd1:    return 1'b1;
      2'd2:    return 1'b0;
      default: return tt[idx];
    endcase
  endfunction

  // Row 0 first, shifted in from the right, so it ends up as the code's MSB.
  function automatic logic [7:0] ref_code(input logic [1:0] k, input logic [7:0] tt);
    logic [7:0] c;
    c = 8'h00;
    for (int r = 0; r < 8; r++) c = {c[6:0], gate(k, 3'(r), tt)};
    return c;
  endfunction

  assign dut_out = gate(gate_kind, {in1, in2, in3}, gate_tt) ^ glitch;

  truth_table_sweeper #(
    .SETTLE_CYCLES(S),
    .SYNC_STAGES  (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .expected (expected),
    .in1      (in1),
    .in2      (in2),
    .in3      (in3),
    .dut_out  (dut_out),
    .busy     (busy),
    .done     (done),
    .table_out(table_out),
    .match    (match)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: row-hold histogram while busy, scoreboard pop on every done pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      foreach (hist[i]) hist[i] = 0;
      last_row = 3'd0;
      order_err = 0;
    end else begin
      if (busy) begin
        if ({in1, in2, in3} != last_row && {in1, in2, in3} != last_row + 3'd1) order_err++;
        last_row = {in1, in2, in3};
        hist[{in1, in2, in3}]++;
      end
      if (done) begin
        if (sb_q.size() == 0) begin
          check("spurious_done", 32'd1, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check("table_out", table_out, mon_e.code);
          check("match", match, mon_e.m);
          check("latency", edge_cnt - mon_e.acc, LAT);
          check("busy_at_done", busy, 0);
          for (int r = 0; r < 7; r++) check($sformatf("row%0d_hold", r), hist[r], PER_ROW);
          check("row7_hold", hist[7], PER_ROW + 1);
          check("row_order", order_err, 0);
        end
        foreach (hist[i]) hist[i] = 0;
        last_row = 3'd0;
        order_err = 0;
      end
    end
  end

  task automatic issue_start(input logic [1:0] k, input logic [7:0] tt, input logic [7:0] exp_v,
                             output int unsigned acc);
    exp_t e;
    @(negedge clk);
    gate_kind = k;
    gate_tt   = tt;
    start     = 1'b1;
    expected  = exp_v;
    acc       = edge_cnt + 1;
    e.code    = ref_code(k, tt);
    e.m       = (e.code == exp_v);
    e.acc     = acc;
    sb_q.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    expected = 8'($urandom);
    check("busy_after_start", busy, 1);
    check("table_cleared", table_out, 0);
    check("match_cleared", match, 0);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < int'(LAT) + 20 && sb_q.size() != 0; n++) @(negedge clk);
    check("done_timeout", sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_table"}, table_out, 0);
    check({tag, "_match"}, match, 0);
    check({tag, "_rows"}, {in1, in2, in3}, 0);
  endtask

  initial begin
    int unsigned acc;
    logic [7:0]  tt;
    logic [7:0]  ev;

    // Reset state.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // XOR3, matching expected; in vote builds a one-cycle glitch lands in the row 3 window.
    issue_start(2'd0, 8'h00, 8'h69, acc);
`ifdef TRUTH_TABLE_SWEEPER_VOTE_EN
    while (edge_cnt < acc + 3 * PER_ROW + S) @(negedge clk);
    glitch = 1'b1;
    @(negedge clk);
    glitch = 1'b0;
`endif
    wait_idle();
    check("xor_code", table_out, 8'h69);
    check("rows_hold_111", {in1, in2, in3}, 3'b111);
    repeat (3) @(negedge clk);
    check("table_hold", table_out, 8'h69);
    check("match_hold", match, 1);

    // XOR3 against the inverted code.
    issue_start(2'd0, 8'h00, 8'h96, acc);
    wait_idle();
    check("xor_vs_96_match", match, 0);

    // Constant gates, started right after the previous done.
    issue_start(2'd1, 8'h00, 8'hFF, acc);
    wait_idle();
    check("const1_code", table_out, 8'hFF);
    issue_start(2'd2, 8'h00, 8'h00, acc);
    wait_idle();
    check("const0_code", table_out, 8'h00);

    // Starts while busy and during the done pulse are ignored.
    issue_start(2'd0, 8'h00, 8'h69, acc);
    while (edge_cnt < acc + 9) @(negedge clk);
    start = 1'b1;
    expected = 8'h00;
    @(negedge clk);
    start = 1'b0;
    while (edge_cnt < acc + LAT - 2) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < int'(LAT) && !done; n++) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_on_done_ignored", busy, 0);
    wait_idle();

    // Mid-sweep reset: everything clears at once and no done follows.
    issue_start(2'd0, 8'h00, 8'h69, acc);
    while (edge_cnt < acc + 20) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    sb_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT) @(negedge clk);
    check("no_done_after_reset", busy, 0);
    issue_start(2'd0, 8'h00, 8'h69, acc);
    wait_idle();
    check("after_reset_code", table_out, 8'h69);

    // Randomized gates and expected codes.
    for (int i = 0; i < 8; i++) begin
      tt = 8'($urandom);
      ev = ($urandom_range(0, 1) == 1) ? ref_code(2'd3, tt) : 8'($urandom);
      issue_start(2'd3, tt, ev, acc);
      wait_idle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
